// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the dual-lane queue and its storage.
package fifo_pkg;

    // Maximum entries moved per port per cycle.
    localparam int unsigned NumLanes = 2;

    // Count width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2w2r.sv
// Queue storage: two synchronous write ports, two asynchronous read ports, no reset.
module fifo_ram_2w2r #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [AW-1:0]     raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write addresses are always distinct when both ports fire (ptr and ptr+1).
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/multi_port_queue.sv
// Circular FIFO accepting up to two pushes and two pops per cycle, first-word-fall-through.
module multi_port_queue
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned AFULL_LVL = DEPTH - 2,
    localparam int unsigned CNT_W    = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        wr_cnt,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [1:0]        rd_cnt,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic              err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfullCnt = CNT_W'(AFULL_LVL);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] free_space;
    logic             push_ok, pop_ok;
    logic [1:0]       push_n, pop_n;
    logic [DATA_W-1:0] ram_rdata0, ram_rdata1;

    // Room is judged on the pre-pop occupancy; a same-cycle pop never frees space.
    assign free_space = DepthCnt - count_q;
    assign push_ok    = (32'(wr_cnt) <= NumLanes) && (CNT_W'(wr_cnt) <= free_space);
    assign pop_ok     = (32'(rd_cnt) <= NumLanes) && (CNT_W'(rd_cnt) <= count_q);
    assign push_n     = push_ok ? wr_cnt : 2'd0;
    assign pop_n      = pop_ok ? rd_cnt : 2'd0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_n);
            rd_ptr_d = rd_ptr_q + AW'(pop_n);
            count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
            err_d    = err_q | ~push_ok | ~pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    fifo_ram_2w2r #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .we0    (~rst & ~flush & (push_n != 2'd0)),
        .waddr0 (wr_ptr_q),
        .wdata0 (wr_data0),
        .we1    (~rst & ~flush & (push_n == 2'd2)),
        .waddr1 (wr_ptr_q + AW'(1)),
        .wdata1 (wr_data1),
        .raddr0 (rd_ptr_q),
        .rdata0 (ram_rdata0),
        .raddr1 (rd_ptr_q + AW'(1)),
        .rdata1 (ram_rdata1)
    );

    assign rd_data0 = (count_q >= CNT_W'(1)) ? ram_rdata0 : '0;
    assign rd_data1 = (count_q >= CNT_W'(2)) ? ram_rdata1 : '0;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCnt);
    assign afull    = (count_q >= AfullCnt);
    assign err      = err_q;

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed self-checking bench for multi_port_queue at DEPTH=8, DATA_W=32, AFULL_LVL=6.
module tb_multi_port_queue;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        wr_cnt;
    logic [DATA_W-1:0] wr_data0, wr_data1;
    logic [1:0]        rd_cnt;
    logic [DATA_W-1:0] rd_data0, rd_data1;
    logic [CNT_W-1:0]  count;
    logic              empty, full, afull, err;

    int n_checks = 0;
    int n_errors = 0;

    multi_port_queue #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .AFULL_LVL (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_cnt   (rd_cnt),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .afull    (afull),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; inputs return to idle afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        flush  = 1'b0;
        wr_cnt = 2'd0;
        rd_cnt = 2'd0;
    endtask

    task automatic push(input logic [1:0] n, input logic [31:0] d0, input logic [31:0] d1);
        wr_cnt   = n;
        wr_data0 = d0;
        wr_data1 = d1;
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_cnt = 2'd0; rd_cnt = 2'd0;
        wr_data0 = '0; wr_data1 = '0;
        #1;
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();

        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_rd0", 64'(rd_data0), 64'd0);
        check("rst_rd1", 64'(rd_data1), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        // Dual push; data must not appear before the edge.
        wr_cnt = 2'd2; wr_data0 = 32'hA000_0000; wr_data1 = 32'hA000_0001;
        #1;
        check("no_bypass", 64'(rd_data0), 64'd0);
        step();
        check("p2_count", 64'(count), 64'd2);
        check("p2_rd0", 64'(rd_data0), 64'hA000_0000);
        check("p2_rd1", 64'(rd_data1), 64'hA000_0001);
        check("p2_empty", 64'(empty), 64'd0);

        push(2'd2, 32'h10, 32'h11);
        push(2'd2, 32'h12, 32'h13);
        check("c6_afull", 64'(afull), 64'd1);
        push(2'd1, 32'h14, 32'hFF);
        check("c7_count", 64'(count), 64'd7);
        check("c7_err", 64'(err), 64'd0);

        // Two entries cannot fit into one free slot.
        push(2'd2, 32'hDEAD, 32'hBEEF);
        check("ovf_count", 64'(count), 64'd7);
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_afull", 64'(afull), 64'd1);
        check("ovf_full", 64'(full), 64'd0);
        check("ovf_head", 64'(rd_data0), 64'hA000_0000);

        push(2'd1, 32'h15, 32'hFF);
        check("c8_full", 64'(full), 64'd1);
        check("c8_count", 64'(count), 64'd8);

        // Full queue: pop 2 accepted, push 1 rejected.
        rd_cnt = 2'd2;
        push(2'd1, 32'h99, 32'h0);
        check("fp_count", 64'(count), 64'd6);
        check("fp_err", 64'(err), 64'd1);
        check("fp_rd0", 64'(rd_data0), 64'h10);
        check("fp_rd1", 64'(rd_data1), 64'h11);
        check("fp_full", 64'(full), 64'd0);

        rst = 1'b1;
        step();
        check("rst2_err", 64'(err), 64'd0);

        // Streaming: push 2 / pop 2 for 20 cycles, pointers wrap repeatedly.
        push(2'd2, 32'hC000_0000, 32'hC000_0001);
        for (int i = 0; i < 20; i++) begin
            check("str_rd0", 64'(rd_data0), 64'(32'hC000_0000 + 32'(2 * i)));
            check("str_rd1", 64'(rd_data1), 64'(32'hC000_0000 + 32'(2 * i + 1)));
            rd_cnt = 2'd2;
            push(2'd2, 32'hC000_0000 + 32'(2 * i + 2), 32'hC000_0000 + 32'(2 * i + 3));
            check("str_count", 64'(count), 64'd2);
        end
        check("str_err", 64'(err), 64'd0);
        check("str_rd0_end", 64'(rd_data0), 64'hC000_0028);

        // Flush overrides a same-cycle push.
        push(2'd2, 32'h1, 32'h2);
        push(2'd1, 32'h3, 32'h0);
        check("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        push(2'd2, 32'h77, 32'h78);
        check("fl_count", 64'(count), 64'd0);
        check("fl_empty", 64'(empty), 64'd1);
        check("fl_rd0", 64'(rd_data0), 64'd0);
        check("fl_err", 64'(err), 64'd0);
        push(2'd1, 32'hB000_0000, 32'h0);
        check("fl_b0", 64'(rd_data0), 64'hB000_0000);
        check("fl_b0_count", 64'(count), 64'd1);

        // Underflow pop is dropped.
        rd_cnt = 2'd2;
        step();
        check("unf_count", 64'(count), 64'd1);
        check("unf_err", 64'(err), 64'd1);
        check("unf_rd0", 64'(rd_data0), 64'hB000_0000);
        rst = 1'b1;
        step();
        check("rst3_err", 64'(err), 64'd0);
        check("rst3_count", 64'(count), 64'd0);
        check("rst3_empty", 64'(empty), 64'd1);

        // Illegal lane count; flush must then leave err set.
        push(2'd3, 32'h5, 32'h6);
        check("ill_count", 64'(count), 64'd0);
        check("ill_err", 64'(err), 64'd1);
        flush = 1'b1;
        step();
        check("fl_keep_err", 64'(err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
